// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_RD   = 2'b00,
        MEM_BYTE = 2'b01,
        MEM_HALF = 2'b10,
        MEM_WORD = 2'b11
    } mem_we_e;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_DBG  = 1;

    // Reads always fetch a full word, so they need four in-range bytes.
    function automatic logic [2:0] access_bytes(mem_we_e we);
        case (we)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; port 1 may hold a bounded burst lock.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter int unsigned LockMax = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       lock_i,
    output logic [1:0] gnt_o
);

    localparam int unsigned CntW = $clog2(LockMax + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(LockMax);

    logic            last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lock_active;

    always_comb begin
        lock_active = lock_i && last_q && (cnt_q < CntMax);
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (lock_active || !last_q) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase

        last_d = last_q;
        if (gnt_o[PORT_CORE]) begin
            last_d = 1'b0;
        end else if (gnt_o[PORT_DBG]) begin
            last_d = 1'b1;
        end

        // Saturate so an uncontested port-1 run cannot wrap and re-arm the lock.
        cnt_d = cnt_q;
        if (!lock_i || gnt_o[PORT_CORE]) begin
            cnt_d = '0;
        end else if (gnt_o[PORT_DBG] && cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core port and the debug/DMA port with range protection.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned RegBits  = 32,
    parameter int unsigned MemBytes = 1024,
    parameter int unsigned LockMax  = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               p0_req_i,
    input  logic [1:0]         p0_we_i,
    input  logic [RegBits-1:0] p0_addr_i,
    input  logic [RegBits-1:0] p0_wdata_i,
    output logic               p0_gnt_o,
    output logic               p0_rvalid_o,
    output logic [RegBits-1:0] p0_rdata_o,
    output logic               p0_err_o,
    input  logic               p1_req_i,
    input  logic [1:0]         p1_we_i,
    input  logic [RegBits-1:0] p1_addr_i,
    input  logic [RegBits-1:0] p1_wdata_i,
    input  logic               p1_lock_i,
    output logic               p1_gnt_o,
    output logic               p1_rvalid_o,
    output logic [RegBits-1:0] p1_rdata_o,
    output logic               p1_err_o,
    output logic [RegBits-1:0] mem_a_o,
    output logic [RegBits-1:0] mem_wd_o,
    output logic [1:0]         mem_we_o,
    input  logic [RegBits-1:0] mem_rd_i
);

    localparam int unsigned ExtW = RegBits + 1;

    logic [1:0]         req, gnt;
    logic               any_gnt, range_err;
    logic [1:0]         we_sel;
    logic [RegBits-1:0] addr_sel, wd_sel, rdata_d;
    logic [ExtW-1:0]    end_addr;

    logic               p0_rvalid_q, p0_err_q, p1_rvalid_q, p1_err_q;
    logic [RegBits-1:0] p0_rdata_q, p1_rdata_q;

    // Requests are masked during reset so no grant or memory write leaks out.
    assign req = {p1_req_i, p0_req_i} & {2{rst_ni}};

    rr_arb2 #(
        .LockMax(LockMax)
    ) u_arb (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .req_i (req),
        .lock_i(p1_lock_i),
        .gnt_o (gnt)
    );

    always_comb begin
        any_gnt   = |gnt;
        we_sel    = gnt[PORT_DBG] ? p1_we_i    : p0_we_i;
        addr_sel  = gnt[PORT_DBG] ? p1_addr_i  : p0_addr_i;
        wd_sel    = gnt[PORT_DBG] ? p1_wdata_i : p0_wdata_i;
        end_addr  = {1'b0, addr_sel} + ExtW'(access_bytes(mem_we_e'(we_sel)));
        range_err = end_addr > ExtW'(MemBytes);

        mem_a_o  = any_gnt ? addr_sel : '0;
        mem_wd_o = any_gnt ? wd_sel   : '0;
        mem_we_o = (any_gnt && !range_err) ? we_sel : MEM_RD;

        rdata_d = (!range_err && we_sel == MEM_RD) ? mem_rd_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p0_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rvalid_q <= 1'b0;
            p1_err_q    <= 1'b0;
            p1_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= gnt[PORT_CORE];
            p0_err_q    <= gnt[PORT_CORE] & range_err;
            p0_rdata_q  <= gnt[PORT_CORE] ? rdata_d : '0;
            p1_rvalid_q <= gnt[PORT_DBG];
            p1_err_q    <= gnt[PORT_DBG] & range_err;
            p1_rdata_q  <= gnt[PORT_DBG] ? rdata_d : '0;
        end
    end

    assign p0_gnt_o    = gnt[PORT_CORE];
    assign p1_gnt_o    = gnt[PORT_DBG];
    assign p0_rvalid_o = p0_rvalid_q;
    assign p0_err_o    = p0_err_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rvalid_o = p1_rvalid_q;
    assign p1_err_o    = p1_err_q;
    assign p1_rdata_o  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte memory model and per-port response scoreboards.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        p0_req, p1_req, p1_lock;
    logic [1:0]  p0_we, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [1:0]  mem_we;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] mem [0:1023];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .p0_req_i   (p0_req),
        .p0_we_i    (p0_we),
        .p0_addr_i  (p0_addr),
        .p0_wdata_i (p0_wdata),
        .p0_gnt_o   (p0_gnt),
        .p0_rvalid_o(p0_rvalid),
        .p0_rdata_o (p0_rdata),
        .p0_err_o   (p0_err),
        .p1_req_i   (p1_req),
        .p1_we_i    (p1_we),
        .p1_addr_i  (p1_addr),
        .p1_wdata_i (p1_wdata),
        .p1_lock_i  (p1_lock),
        .p1_gnt_o   (p1_gnt),
        .p1_rvalid_o(p1_rvalid),
        .p1_rdata_o (p1_rdata),
        .p1_err_o   (p1_err),
        .mem_a_o    (mem_a),
        .mem_wd_o   (mem_wd),
        .mem_we_o   (mem_we),
        .mem_rd_i   (mem_rd)
    );

    // Combinational little-endian read of four bytes starting at mem_a.
    always_comb begin
        mem_rd = '0;
        for (int i = 0; i < 4; i++) begin
            if (mem_a + 32'(i) < 32'd1024) begin
                mem_rd[8*i +: 8] = mem[mem_a[9:0] + 10'(i)];
            end
        end
    end

    // Memory model: capture the request mid-cycle, commit at the closing edge.
    initial begin : mem_model
        logic [1:0]  cwe;
        logic [31:0] ca, cd;
        int          nb;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[16] = 8'hEF; mem[17] = 8'hBE; mem[18] = 8'hAD; mem[19] = 8'hDE;
        mem[20] = 8'h0D; mem[21] = 8'hF0; mem[22] = 8'hFE; mem[23] = 8'hCA;
        forever begin
            @(negedge clk);
            cwe = mem_we; ca = mem_a; cd = mem_wd;
            @(posedge clk);
            nb = (cwe == 2'b01) ? 1 : (cwe == 2'b10) ? 2 : (cwe == 2'b11) ? 4 : 0;
            for (int i = 0; i < nb; i++) begin
                if (ca + 32'(i) < 32'd1024) mem[ca[9:0] + 10'(i)] = cd[8*i +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Response monitor: every rvalid must match the oldest expectation, one cycle after its grant.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (p0_rvalid) begin
            if (q0.size() == 0) begin
                chk("p0_stray_rvalid", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("p0_rsp_latency", 32'(cyc), 32'(e.cyc + 1));
                chk("p0_err", {31'd0, p0_err}, {31'd0, e.err});
                chk("p0_rdata", p0_rdata, e.rdata);
            end
        end
        if (p1_rvalid) begin
            if (q1.size() == 0) begin
                chk("p1_stray_rvalid", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("p1_rsp_latency", 32'(cyc), 32'(e.cyc + 1));
                chk("p1_err", {31'd0, p1_err}, {31'd0, e.err});
                chk("p1_rdata", p1_rdata, e.rdata);
            end
        end
    end

    task automatic drive(input logic r0, input logic [1:0] w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic [1:0] w1,
                         input logic [31:0] a1, input logic [31:0] d1, input logic lk);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_lock = lk;
    endtask

    // One cycle: starts 1 after a posedge, checks grant/mem_we mid-cycle, queues the response.
    task automatic step(input logic r0, input logic [1:0] w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic r1, input logic [1:0] w1,
                        input logic [31:0] a1, input logic [31:0] d1, input logic lk,
                        input logic [1:0] eg, input logic [1:0] ewe, input logic ee,
                        input logic [31:0] erd);
        drive(r0, w0, a0, d0, r1, w1, a1, d1, lk);
        #4;
        chk("gnt{p1,p0}", {30'd0, p1_gnt, p0_gnt}, {30'd0, eg});
        chk("mem_we", {30'd0, mem_we}, {30'd0, ewe});
        if (eg[0]) q0.push_back('{err: ee, rdata: erd, cyc: cyc});
        if (eg[1]) q1.push_back('{err: ee, rdata: erd, cyc: cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic p0_only(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] ewe, input logic ee, input logic [31:0] erd);
        step(1'b1, w, a, d, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 2'b01, ewe, ee, erd);
    endtask

    task automatic p1_only(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] ewe, input logic ee, input logic [31:0] erd);
        step(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, w, a, d, 1'b0, 2'b10, ewe, ee, erd);
    endtask

    // Both ports read: p0 @0x10 (DEADBEEF), p1 @0x14 (CAFEF00D); expected winner given.
    task automatic both_rd(input logic lk, input logic p1_wins);
        if (p1_wins) begin
            step(1'b1, 2'b00, 32'h10, 32'd0, 1'b1, 2'b00, 32'h14, 32'd0, lk,
                 2'b10, 2'b00, 1'b0, 32'hCAFEF00D);
        end else begin
            step(1'b1, 2'b00, 32'h10, 32'd0, 1'b1, 2'b00, 32'h14, 32'd0, lk,
                 2'b01, 2'b00, 1'b0, 32'hDEADBEEF);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(1'b1, 2'b00, 32'h10, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        #12;
        chk("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
        chk("rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        chk("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
        chk("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
        chk("rst_p0_err", {31'd0, p0_err}, 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_mem_we", {30'd0, mem_we}, 32'd0);
        p0_req = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Single-port read right after reset.
        p0_only(2'b00, 32'h10, 32'd0, 2'b00, 1'b0, 32'hDEADBEEF);

        // Round robin without lock: p1 alone, then contested cycles alternate p0, p1, ...
        p1_only(2'b00, 32'h14, 32'd0, 2'b00, 1'b0, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) both_rd(1'b0, (i % 2) == 1);

        // Burst lock: eight port-1 grants then one port-0 grant, twice.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 9; k++) both_rd(1'b1, k < 8);
        end

        // Store by p1, then read-after-write by p0.
        p1_only(2'b11, 32'h20, 32'h11223344, 2'b11, 1'b0, 32'd0);
        p0_only(2'b00, 32'h20, 32'd0, 2'b00, 1'b0, 32'h11223344);

        // Range boundaries.
        p0_only(2'b00, 32'd1022, 32'd0, 2'b00, 1'b1, 32'd0);
        p0_only(2'b01, 32'd1023, 32'h000000AB, 2'b01, 1'b0, 32'd0);
        p0_only(2'b10, 32'd1023, 32'h0000FFFF, 2'b00, 1'b1, 32'd0);
        p0_only(2'b00, 32'd1020, 32'd0, 2'b00, 1'b0, 32'hAB000000);
        p0_only(2'b00, 32'hFFFFFFFE, 32'd0, 2'b00, 1'b1, 32'd0);
        p1_only(2'b11, 32'd1021, 32'h55555555, 2'b00, 1'b1, 32'd0);

        // Reset in the middle of a granted access.
        p0_only(2'b00, 32'h10, 32'd0, 2'b00, 1'b0, 32'hDEADBEEF);
        drive(1'b1, 2'b00, 32'h10, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        #4;
        chk("pre_rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
        chk("mid_rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
        chk("mid_rst_mem_we", {30'd0, mem_we}, 32'd0);
        p0_req = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
        rst_ni = 1'b1;
        both_rd(1'b0, 1'b0);
        step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0,
             2'b00, 2'b00, 1'b0, 32'd0);
        chk("responses_outstanding", 32'(q0.size() + q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
